// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing sequencer: synchronises the button and vehicle detector,
// latches crossing requests and steps the road/pedestrian lamps on a prescaled tick.
module ped_crossing_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_PED_GREEN = 8,
    parameter int T_PED_FLASH = 4,
    parameter int T_RED_YEL   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PED_BUTT,
    input  logic       ROAD_DET,
    output logic       ROAD_RED,
    output logic       ROAD_YELLOW,
    output logic       ROAD_GREEN,
    output logic       PED_RED,
    output logic       PED_GREEN,
    output logic       PED_WAIT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_ROAD_GO   = 3'd0,
        S_ROAD_YEL  = 3'd1,
        S_ALL_RED1  = 3'd2,
        S_PED_GO    = 3'd3,
        S_PED_FLASH = 3'd4,
        S_ALL_RED2  = 3'd5,
        S_RED_YEL   = 3'd6,
        S_BAD       = 3'd7
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer must hold the longest dwell of any state, not only the green limit.
    localparam int T_TOP = max2(max2(max2(T_MAX_GREEN, T_YELLOW), max2(T_ALL_RED, T_PED_GREEN)),
                                max2(T_PED_FLASH, T_RED_YEL));
    localparam int TW = $clog2(T_TOP + 1);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [TW:0]   N_MIN    = (TW+1)'(T_MIN_GREEN);
    localparam logic [TW:0]   N_MAX    = (TW+1)'(T_MAX_GREEN);
    localparam logic [TW-1:0] T_SAT    = TW'(T_MAX_GREEN);

    function automatic logic [TW:0] dwell(input state_e s);
        logic [TW:0] d;
        d = '0;
        case (s)
            S_ROAD_YEL:             d = (TW+1)'(T_YELLOW);
            S_ALL_RED1, S_ALL_RED2: d = (TW+1)'(T_ALL_RED);
            S_PED_GO:               d = (TW+1)'(T_PED_GREEN);
            S_PED_FLASH:            d = (TW+1)'(T_PED_FLASH);
            S_RED_YEL:              d = (TW+1)'(T_RED_YEL);
            default:                d = '0;
        endcase
        return d;
    endfunction

    function automatic state_e succ(input state_e s);
        state_e r;
        r = S_ROAD_GO;
        case (s)
            S_ROAD_GO:   r = S_ROAD_YEL;
            S_ROAD_YEL:  r = S_ALL_RED1;
            S_ALL_RED1:  r = S_PED_GO;
            S_PED_GO:    r = S_PED_FLASH;
            S_PED_FLASH: r = S_ALL_RED2;
            S_ALL_RED2:  r = S_RED_YEL;
            default:     r = S_ROAD_GO;
        endcase
        return r;
    endfunction

    logic          ped_s1_q, ped_s2_q, ped_s3_q, rise_q;
    logic          det_s1_q, det_s2_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] t_q, t_d;
    logic [TW:0]   n;
    logic          req_q, req_d;
    logic          tick, changed, set_ok;
    // Lamp vector order: road red, road yellow, road green, ped red, ped green.
    logic [4:0]    lamp_q, lamp_d;

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        n       = (TW+1)'(t_q) + (TW+1)'(1);
        state_d = state_q;
        case (state_q)
            S_ROAD_GO: begin
                if (tick && req_q && (n >= N_MIN) && (!det_s2_q || (n >= N_MAX)))
                    state_d = S_ROAD_YEL;
            end
            S_ROAD_YEL, S_ALL_RED1, S_PED_GO, S_PED_FLASH, S_ALL_RED2, S_RED_YEL: begin
                if (tick && (n == dwell(state_q)))
                    state_d = succ(state_q);
            end
            default: state_d = S_ROAD_GO;
        endcase

        changed = (state_d != state_q);
        cnt_d   = (changed || tick) ? '0 : cnt_q + CW'(1);

        t_d = t_q;
        if (changed)
            t_d = '0;
        else if (tick && !((state_q == S_ROAD_GO) && (t_q >= T_SAT)))
            t_d = t_q + TW'(1);

        set_ok = state_q inside {S_ROAD_GO, S_ROAD_YEL, S_ALL_RED1, S_ALL_RED2, S_RED_YEL};
        req_d  = req_q | (rise_q & set_ok);
        if ((state_d == S_PED_GO) && (state_q != S_PED_GO))
            req_d = 1'b0;

        lamp_d = 5'b00110;
        case (state_d)
            S_ROAD_GO:              lamp_d = 5'b00110;
            S_ROAD_YEL:             lamp_d = 5'b01010;
            S_ALL_RED1, S_ALL_RED2: lamp_d = 5'b10010;
            S_PED_GO:               lamp_d = 5'b10001;
            S_PED_FLASH:            lamp_d = {4'b1000, ~t_d[0]};
            S_RED_YEL:              lamp_d = 5'b11010;
            default:                lamp_d = 5'b00110;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ped_s1_q <= 1'b0;
            ped_s2_q <= 1'b0;
            ped_s3_q <= 1'b0;
            rise_q   <= 1'b0;
            det_s1_q <= 1'b0;
            det_s2_q <= 1'b0;
            state_q  <= S_ROAD_GO;
            cnt_q    <= '0;
            t_q      <= '0;
            req_q    <= 1'b0;
            lamp_q   <= 5'b00110;
        end else begin
            ped_s1_q <= PED_BUTT;
            ped_s2_q <= ped_s1_q;
            ped_s3_q <= ped_s2_q;
            rise_q   <= ped_s2_q & ~ped_s3_q;
            det_s1_q <= ROAD_DET;
            det_s2_q <= det_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            req_q    <= req_d;
            lamp_q   <= lamp_d;
        end
    end

    assign {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN} = lamp_q;
    assign PED_WAIT = req_q;
    assign STATE    = state_q;

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian-crossing sequencer that consumes the board's `PED_BUTT` and `ROAD_DET` inputs and drives the road and pedestrian lamp outputs. It replaces the free-running counter pattern on the lamp pins in the top level. It sits between the reset bridge and the lamp pins and runs entirely in the `CLK` domain. It provides:
- button and detector synchronization,
- a latched crossing request,
- a prescaled time base,
- a seven-state light sequencer with minimum and maximum road-green times.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000 — `CLK` cycles per time unit (tick); must be ≥ 2.
- `T_MIN_GREEN`, 10 — minimum road green, in ticks.
- `T_MAX_GREEN`, 30 — road green after which a pending request wins even while `ROAD_DET`=1.
- `T_YELLOW`, 3 — road yellow.
- `T_ALL_RED`, 2 — all-red clearance, used in both directions.
- `T_PED_GREEN`, 8 — steady pedestrian green.
- `T_PED_FLASH`, 4 — flashing pedestrian green.
- `T_RED_YEL`, 2 — road red+yellow before green.
- Constraints: every `T_*` ≥ 1; `T_MAX_GREEN` ≥ `T_MIN_GREEN`.

Ports:
- `CLK` input 1 — single clock.
- `RST` input 1 — reset, synchronous, active-high.
- `PED_BUTT` input 1 — asynchronous pedestrian button, active-high.
- `ROAD_DET` input 1 — asynchronous vehicle detector, active-high.
- `ROAD_RED`, `ROAD_YELLOW`, `ROAD_GREEN` output 1 each — road lamps.
- `PED_RED`, `PED_GREEN` output 1 each — pedestrian lamps.
- `PED_WAIT` output 1 — crossing request pending.
- `STATE` output 3 — current state encoding, for debug and LEDs.

## Operation
- **Synchronizers:** `PED_BUTT` and `ROAD_DET` each pass through a 2-FF synchronizer. A registered copy of the synchronized button gives a rising-edge pulse `btn_rise`.
- **Request latch `req`:**
  - Set by `btn_rise` in ROAD_GO, ROAD_YEL, ALL_RED1, ALL_RED2, RED_YEL.
  - Cleared on the edge entering PED_GO.
  - `btn_rise` in PED_GO or PED_FLASH is ignored.
  - If set and clear happen in the same cycle, clear wins.
  - `PED_WAIT` = `req`.
- **Prescaler:** counts 0..`TICK_DIV`-1. `tick` = 1 when the count equals `TICK_DIV`-1. The prescaler is reset to 0 on every state change.
- **State timer `t`:** counts ticks since entering the current state; reset to 0 on state change. Width is enough to hold `T_MAX_GREEN`.
- **States (`STATE` value) and lamps:**
  - ROAD_GO (0): road G, ped R.
  - ROAD_YEL (1): road Y, ped R.
  - ALL_RED1 (2): road R, ped R.
  - PED_GO (3): road R, ped G.
  - PED_FLASH (4): road R, ped G blinking, ped R off.
  - ALL_RED2 (5): road R, ped R.
  - RED_YEL (6): road R+Y, ped R.
- **Transitions:** all evaluated only on a `tick` cycle. Let `n` = `t`+1, the count including the current tick.
  - ROAD_GO → ROAD_YEL when `req` && `n` ≥ `T_MIN_GREEN` && (!`ROAD_DET`_sync || `n` ≥ `T_MAX_GREEN`).
  - Otherwise ROAD_GO holds. `t` saturates at `T_MAX_GREEN`.
  - Every other state advances to the next state when `n` = its `T_*`:
    - ROAD_YEL → ALL_RED1 → PED_GO → PED_FLASH → ALL_RED2 → RED_YEL → ROAD_GO.
    - ROAD_YEL, PED_GO, PED_FLASH and RED_YEL use `T_YELLOW`, `T_PED_GREEN`, `T_PED_FLASH` and `T_RED_YEL` respectively.
    - Both ALL_RED states use `T_ALL_RED`.
- **Flash:** in PED_FLASH, `PED_GREEN` = ~`t`[0], so it is lit during even tick intervals starting from entry.
- **Illegal `STATE` value (7):** next state is ROAD_GO with `req` kept.
- **Reset:**
  - State = ROAD_GO, `t` = 0, prescaler = 0, `req` = 0, synchronizers = 0.
  - Outputs: `ROAD_GREEN`=1, `PED_RED`=1, all other lamps 0, `PED_WAIT`=0, `STATE`=0.
  - Reset mid-sequence, including during PED_GO, returns to this state on the next edge.

## Timing
- Lamp outputs and `STATE` are registered and decoded from next-state. They change on the same edge as the state register. Lamps are glitch-free.
- Non-ROAD_GO state dwell is exactly `T_x`×`TICK_DIV` cycles.
- ROAD_GO dwell is k×`TICK_DIV` cycles for the first qualifying k ≥ `T_MIN_GREEN`.
- `PED_BUTT` rising (meeting setup) → `PED_WAIT`=1 after the 4th `CLK` edge: 2 sync stages, 1 edge register, 1 latch.
- `ROAD_DET` is seen by the sequencer 2 edges after the pin changes.
- A request raised after `T_MIN_GREEN` has elapsed with `ROAD_DET`=0 is served at the next tick boundary.

## Test plan
All scenarios use `TICK_DIV`=4, `T_MIN_GREEN`=3, `T_MAX_GREEN`=6, `T_YELLOW`=2, `T_ALL_RED`=1, `T_PED_GREEN`=3, `T_PED_FLASH`=2, `T_RED_YEL`=1.

1. **Idle after reset:** `RST` for 2 cycles, no inputs → `ROAD_GREEN`=1, `PED_RED`=1, `STATE`=0 for 200 cycles; `PED_WAIT`=0.
2. **Single press:** `PED_BUTT` pulsed 3 cycles right after reset, `ROAD_DET`=0.
   - `PED_WAIT`=1 from 4 edges later.
   - ROAD_GO leaves at cycle 12, then ROAD_YEL lasts 8, ALL_RED1 4, PED_GO 12, PED_FLASH 8, ALL_RED2 4, RED_YEL 4 cycles.
   - `PED_WAIT` drops on PED_GO entry.
   - During PED_FLASH, `PED_GREEN` reads 1,1,1,1,0,0,0,0.
3. **Max-green override:** press with `ROAD_DET`=1 held → ROAD_GO lasts exactly 24 cycles (6 ticks); press with `ROAD_DET`=0 → 12 cycles.
4. **Presses in ped phases:** a press during PED_GO does not set `PED_WAIT`; a press in ALL_RED2 sets it, and ROAD_GO after the next RED_YEL lasts exactly 12 cycles.
5. **Reset mid-PED_GO:** `RST` asserted one cycle → next edge gives `STATE`=0, `ROAD_GREEN`=1, `PED_GREEN`=0, `PED_WAIT`=0.
6. **Glitch rejection:** a 1-cycle `PED_BUTT` pulse aligned to sample setup latches; no lamp output is ever high together with a conflicting lamp (`ROAD_GREEN`&&`PED_GREEN`, `ROAD_GREEN`&&`ROAD_RED`); checked by assertion for the whole run.
